// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump engine.
//   dump_state_e  : FSM state encoding (IDLE, READ, SEND, DONE)
//   NUM_REGS_DEF  : default number of registers scanned
//   DATA_W_DEF    : default register data width
package reg_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_e;

  localparam int NUM_REGS_DEF = 32;
  localparam int DATA_W_DEF   = 64;

endpackage

// File: rtl/register_dump.sv
// register_dump: walks the register file's second read port and streams
// every architectural register out over a valid/ready interface while the
// CPU is halted.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begins a dump when idle (ignored otherwise)
//   abort      in   cancels an in-progress dump, no done pulse
//   rf_addr    out  register index driven to the register file read port
//   rf_data    in   combinational read data for rf_addr
//   out_valid  out  out_data/out_index hold a register value
//   out_ready  in   consumer accepts the beat when out_valid && out_ready
//   out_data   out  captured register value
//   out_index  out  index of out_data
//   busy       out  high whenever the engine is not idle
//   done       out  one-cycle pulse after the last beat is accepted
import reg_dump_pkg::*;

module register_dump #(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done
);

  // Terminal index compare rather than a wrap, so NUM_REGS need not be a power of 2.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_r;
  dump_state_e       state_s;
  logic [ADDR_W-1:0] index_r;
  logic [ADDR_W-1:0] index_s;
  logic              capture_s;
  logic              out_valid_r;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] out_data_r;
  logic [ADDR_W-1:0] out_index_r;

  // Next-state, next-index and snapshot-enable decode.
  always_comb begin
    state_s   = state_r;
    index_s   = index_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        // Start wins over a same-cycle abort: abort has no meaning here.
        if (start) begin
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
        index_s = {ADDR_W{1'b0}};
      end
      READ: begin
        if (abort) begin
          state_s = IDLE;
          index_s = {ADDR_W{1'b0}};
        end else begin
          capture_s = 1'b1;
          state_s   = SEND;
        end
      end
      SEND: begin
        // Abort outranks the handshake: that beat is treated as not transferred.
        if (abort) begin
          state_s = IDLE;
          index_s = {ADDR_W{1'b0}};
        end else if (out_ready) begin
          if (index_r == LAST_IDX) begin
            state_s = DONE;
          end else begin
            state_s = READ;
            index_s = index_r + ADDR_W'(1);
          end
        end else begin
          state_s = SEND;
        end
      end
      DONE: begin
        state_s = IDLE;
        index_s = {ADDR_W{1'b0}};
      end
      default: begin
        state_s = IDLE;
        index_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, index and registered status outputs (decoded from the next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      index_r     <= {ADDR_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      index_r     <= index_s;
      out_valid_r <= (state_s == SEND);
      busy_r      <= (state_s != IDLE);
      done_r      <= (state_s == DONE);
    end
  end

  // Snapshot of the register value taken at the end of its READ cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= {DATA_W{1'b0}};
      out_index_r <= {ADDR_W{1'b0}};
    end else if (capture_s) begin
      out_data_r  <= rf_data;
      out_index_r <= index_r;
    end else begin
      out_data_r  <= out_data_r;
      out_index_r <= out_index_r;
    end
  end

  assign rf_addr   = index_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign out_data  = out_data_r;
  assign out_index = out_index_r;

endmodule
